bootrom_arbiter: RTL

- Two-master, one-slave Wishbone arbiter in front of the boot ROM.
- Master 0 is the instruction-fetch port. Master 1 is the data/debug port, used for literal-pool loads and the debugger reading ROM.
- Round-robin grant, locked for the whole bus cycle (held while the granted master keeps cyc asserted).
- Slave signals are muxed from the granted master; the slave's combinational ack is routed back to that master only.

---
 rtl/bootrom_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter: two-master round-robin Wishbone arbiter for the boot ROM; optional BOOTROM_ARB_TIMEOUT_EN adds a stall timeout returning err
module bootrom_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SELW    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic            m0_tga_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [SELW-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic            m1_tga_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [SELW-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic            s_tga_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [SELW-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      gnt_o
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic g0, g1;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bootrom_arbiter: TIMEOUT must be in 1..255");
  end

  // next grant: ties go to the master that was not served last; release hands off with no bubble
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: state_d = (m0_cyc_i & m1_cyc_i) ? (last_q ? GNT0 : GNT1) :
                      m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
      GNT0: if (!m0_cyc_i) begin
        last_d  = 1'b0;
        state_d = m1_cyc_i ? GNT1 : IDLE;
      end
      GNT1: if (!m1_cyc_i) begin
        last_d  = 1'b1;
        state_d = m0_cyc_i ? GNT0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // grant and round-robin pointer registers; master 0 wins the first tie after reset
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign g0       = state_q == GNT0;
  assign g1       = state_q == GNT1;
  assign gnt_o    = {g1, g0};
  assign s_cyc_o  = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
  assign s_stb_o  = (g0 & m0_cyc_i & m0_stb_i) | (g1 & m1_cyc_i & m1_stb_i);
  assign s_we_o   = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
  assign s_tga_o  = g0 ? m0_tga_i : g1 ? m1_tga_i : 1'b0;
  assign s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
  assign s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
  assign s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & g0;
  assign m1_ack_o = s_ack_i & g1;

`ifdef BOOTROM_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic stall, err;

  // count stalled strobes; err fires on the TIMEOUT-th stalled cycle, ack always wins
  always_comb begin
    stall = s_stb_o & ~s_ack_i;
    err   = stall & (cnt_q + 8'd1 == 8'(TIMEOUT));
    cnt_d = (state_d != state_q || s_ack_i || err) ? 8'd0 : stall ? cnt_q + 8'd1 : cnt_q;
  end

  // stall counter register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  end

  assign m0_err_o = err & g0;
  assign m1_err_o = err & g1;
`else
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif
endmodule
